usb2_ep_multibuf: RTL and testbench

- Parametrised successor to the USB 2.0 endpoint buffer: N-deep ring of equal-size packet buffers instead of a fixed ping-pong pair.
- Producer side (protocol RX or application) fills a buffer and commits it with a length. The consumer drains it and arms/releases it.
- Single clock domain; sits between the USB 2.0 protocol layer and the endpoint application logic.
- Also owns the per-endpoint data-toggle sequencer, with mode-aware sequencing and an explicit clear.

---
 rtl/usb2_ep_pkg.sv | 14 +
 rtl/usb2_ep_ram.sv | 37 +++
 rtl/usb2_ep_multibuf.sv | 166 ++++++++++++++++
 tb/tb_usb2_ep_multibuf.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb2_ep_pkg.sv
// Shared constants for the USB 2.0 multi-buffer endpoint: transfer modes and PID toggle codes.
package usb2_ep_pkg;

    localparam logic [1:0] EP_MODE_CONTROL   = 2'd0;
    localparam logic [1:0] EP_MODE_ISOCH     = 2'd1;
    localparam logic [1:0] EP_MODE_BULK      = 2'd2;
    localparam logic [1:0] EP_MODE_INTERRUPT = 2'd3;

    localparam logic [1:0] DATA_TOGGLE_0 = 2'b00;
    localparam logic [1:0] DATA_TOGGLE_1 = 2'b01;
    localparam logic [1:0] DATA_TOGGLE_2 = 2'b10;
    localparam logic [1:0] DATA_TOGGLE_M = 2'b11;

endpackage

// File: rtl/usb2_ep_ram.sv
// Simple dual-port packet RAM, single clock, registered read port (1-cycle latency).
module usb2_ep_ram
    import usb2_ep_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              phy_clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_p1;

    always_ff @(posedge phy_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read stage: only the output register is reset so the array itself can map onto block RAM.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_p1 <= '0;
        end else begin
            rd_data_p1 <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_p1;

endmodule

// File: rtl/usb2_ep_multibuf.sv
// N-deep ring of packet buffers with commit/arm handshakes and data-toggle sequencer.
// Optional overflow statistics ports enabled by defining USB2_EP_OVERFLOW_STAT_EN.
module usb2_ep_multibuf
    import usb2_ep_pkg::*;
#(
    parameter int NUM_BUF    = 2,
    parameter int BUF_ADDR_W = 9,
    parameter int DATA_W     = 8,
    parameter int LEN_W      = BUF_ADDR_W + 1
) (
    input  logic                      phy_clk,
    input  logic                      reset_n,
    input  logic [BUF_ADDR_W-1:0]     buf_in_addr,
    input  logic [DATA_W-1:0]         buf_in_data,
    input  logic                      buf_in_wren,
    output logic                      buf_in_ready,
    input  logic                      buf_in_commit,
    input  logic [LEN_W-1:0]          buf_in_commit_len,
    output logic                      buf_in_commit_ack,
    input  logic [BUF_ADDR_W-1:0]     buf_out_addr,
    output logic [DATA_W-1:0]         buf_out_q,
    output logic [LEN_W-1:0]          buf_out_len,
    output logic                      buf_out_hasdata,
    input  logic                      buf_out_arm,
    output logic                      buf_out_arm_ack,
    input  logic [1:0]                mode,
    input  logic                      data_toggle_act,
    input  logic                      data_toggle_clear,
    output logic [1:0]                data_toggle,
    output logic [$clog2(NUM_BUF):0]  buf_count
`ifdef USB2_EP_OVERFLOW_STAT_EN
    ,
    output logic                      buf_in_overflow,
    output logic [7:0]                overflow_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_BUF);
    localparam int CNT_W = PTR_W + 1;
    localparam int RAM_W = PTR_W + BUF_ADDR_W;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(2**BUF_ADDR_W)) begin
            return LEN_W'(2**BUF_ADDR_W);
        end
        return len;
    endfunction

    function automatic logic [1:0] next_toggle(input logic [1:0] cur, input logic [1:0] ep_mode);
        if (ep_mode == EP_MODE_ISOCH) begin
            return DATA_TOGGLE_0;
        end
        return (cur == DATA_TOGGLE_1) ? DATA_TOGGLE_0 : DATA_TOGGLE_1;
    endfunction

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [LEN_W-1:0] len_q [NUM_BUF];
    logic             commit_ack_q;
    logic             arm_ack_q;
    logic [1:0]       toggle_q;

    logic commit_ok;
    logic arm_ok;
    logic ram_wr_en;

    // Both handshakes are judged against the count held at the start of the cycle.
    assign buf_in_ready    = (count != CNT_W'(NUM_BUF));
    assign buf_out_hasdata = (count != '0);
    assign commit_ok       = buf_in_commit && buf_in_ready;
    assign arm_ok          = buf_out_arm && buf_out_hasdata;
    assign ram_wr_en       = buf_in_wren && buf_in_ready;

    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            commit_ack_q <= 1'b0;
            arm_ack_q    <= 1'b0;
            for (int i = 0; i < NUM_BUF; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            commit_ack_q <= commit_ok;
            arm_ack_q    <= arm_ok;
            if (commit_ok) begin
                len_q[wr_ptr] <= clamp_len(buf_in_commit_len);
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (arm_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({commit_ok, arm_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q <= DATA_TOGGLE_0;
        end else if (data_toggle_clear) begin
            toggle_q <= DATA_TOGGLE_0;
        end else if (data_toggle_act) begin
            toggle_q <= next_toggle(toggle_q, mode);
        end
    end

    assign buf_in_commit_ack = commit_ack_q;
    assign buf_out_arm_ack   = arm_ack_q;
    assign buf_out_len       = len_q[rd_ptr];
    assign data_toggle       = toggle_q;
    assign buf_count         = count;

    usb2_ep_ram #(
        .ADDR_W (RAM_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .phy_clk (phy_clk),
        .reset_n (reset_n),
        .wr_en   (ram_wr_en),
        .wr_addr ({wr_ptr, buf_in_addr}),
        .wr_data (buf_in_data),
        .rd_addr ({rd_ptr, buf_out_addr}),
        .rd_data (buf_out_q)
    );

`ifdef USB2_EP_OVERFLOW_STAT_EN
    function automatic logic [7:0] sat_add8(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    logic       overflow_q;
    logic [7:0] overflow_cnt_q;
    logic       drop_prev;
    logic       drop_now;
    logic       commit_rej;

    // A burst of dropped writes counts once, on its first cycle.
    assign drop_now   = buf_in_wren && !buf_in_ready;
    assign commit_rej = buf_in_commit && !buf_in_ready;

    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q     <= 1'b0;
            overflow_cnt_q <= '0;
            drop_prev      <= 1'b0;
        end else begin
            overflow_q     <= commit_rej;
            drop_prev      <= drop_now;
            overflow_cnt_q <= sat_add8(overflow_cnt_q,
                                       {1'b0, commit_rej} + {1'b0, drop_now && !drop_prev});
        end
    end

    assign buf_in_overflow = overflow_q;
    assign overflow_cnt    = overflow_cnt_q;
`endif

endmodule

// File: tb/tb_usb2_ep_multibuf.sv
// Directed self-checking bench for usb2_ep_multibuf (NUM_BUF=4, BUF_ADDR_W=9).
module tb_usb2_ep_multibuf;
    import usb2_ep_pkg::*;

    localparam int NUM_BUF    = 4;
    localparam int BUF_ADDR_W = 9;
    localparam int DATA_W     = 8;
    localparam int LEN_W      = BUF_ADDR_W + 1;

    logic                  phy_clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [BUF_ADDR_W-1:0] buf_in_addr = '0;
    logic [DATA_W-1:0]     buf_in_data = '0;
    logic                  buf_in_wren = 1'b0;
    logic                  buf_in_ready;
    logic                  buf_in_commit = 1'b0;
    logic [LEN_W-1:0]      buf_in_commit_len = '0;
    logic                  buf_in_commit_ack;
    logic [BUF_ADDR_W-1:0] buf_out_addr = '0;
    logic [DATA_W-1:0]     buf_out_q;
    logic [LEN_W-1:0]      buf_out_len;
    logic                  buf_out_hasdata;
    logic                  buf_out_arm = 1'b0;
    logic                  buf_out_arm_ack;
    logic [1:0]            mode = EP_MODE_BULK;
    logic                  data_toggle_act = 1'b0;
    logic                  data_toggle_clear = 1'b0;
    logic [1:0]            data_toggle;
    logic [2:0]            buf_count;
`ifdef USB2_EP_OVERFLOW_STAT_EN
    logic                  buf_in_overflow;
    logic [7:0]            overflow_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 phy_clk = ~phy_clk;

    usb2_ep_multibuf #(
        .NUM_BUF    (NUM_BUF),
        .BUF_ADDR_W (BUF_ADDR_W),
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W)
    ) dut (
        .phy_clk           (phy_clk),
        .reset_n           (reset_n),
        .buf_in_addr       (buf_in_addr),
        .buf_in_data       (buf_in_data),
        .buf_in_wren       (buf_in_wren),
        .buf_in_ready      (buf_in_ready),
        .buf_in_commit     (buf_in_commit),
        .buf_in_commit_len (buf_in_commit_len),
        .buf_in_commit_ack (buf_in_commit_ack),
        .buf_out_addr      (buf_out_addr),
        .buf_out_q         (buf_out_q),
        .buf_out_len       (buf_out_len),
        .buf_out_hasdata   (buf_out_hasdata),
        .buf_out_arm       (buf_out_arm),
        .buf_out_arm_ack   (buf_out_arm_ack),
        .mode              (mode),
        .data_toggle_act   (data_toggle_act),
        .data_toggle_clear (data_toggle_clear),
        .data_toggle       (data_toggle),
        .buf_count         (buf_count)
`ifdef USB2_EP_OVERFLOW_STAT_EN
        ,
        .buf_in_overflow   (buf_in_overflow),
        .overflow_cnt      (overflow_cnt)
`endif
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge phy_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic write_byte(input int addr, input int data);
        buf_in_addr = BUF_ADDR_W'(addr);
        buf_in_data = DATA_W'(data);
        buf_in_wren = 1'b1;
        tick();
        buf_in_wren = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        n_tests++; if (buf_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b expected 1", buf_in_ready); end
        n_tests++; if (buf_out_hasdata !== 1'b0) begin n_fail++; $display("FAIL reset_hasdata got %0b expected 0", buf_out_hasdata); end
        n_tests++; if (buf_out_len !== '0) begin n_fail++; $display("FAIL reset_len got %0d expected 0", buf_out_len); end
        n_tests++; if (buf_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d expected 0", buf_count); end
        n_tests++; if (data_toggle !== 2'b00) begin n_fail++; $display("FAIL reset_toggle got %0d expected 0", data_toggle); end
        n_tests++; if ({buf_in_commit_ack, buf_out_arm_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks got %b expected 00", {buf_in_commit_ack, buf_out_arm_ack}); end
        n_tests++; if (buf_out_q !== 8'h00) begin n_fail++; $display("FAIL reset_q got %0h expected 0", buf_out_q); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 4; i++) write_byte(i, 8'hA0 + i);
        buf_in_commit = 1'b1;
        buf_in_commit_len = 10'd4;
        tick();
        buf_in_commit = 1'b0;
        n_tests++; if (buf_in_commit_ack !== 1'b1) begin n_fail++; $display("FAIL commit_ack got %0b expected 1", buf_in_commit_ack); end
        n_tests++; if (buf_out_hasdata !== 1'b1) begin n_fail++; $display("FAIL wr_hasdata got %0b expected 1", buf_out_hasdata); end
        n_tests++; if (buf_out_len !== 10'd4) begin n_fail++; $display("FAIL wr_len got %0d expected 4", buf_out_len); end
        for (int i = 0; i < 4; i++) begin
            buf_out_addr = BUF_ADDR_W'(i);
            tick();
            if (i == 0) begin
                n_tests++; if (buf_in_commit_ack !== 1'b0) begin n_fail++; $display("FAIL commit_ack_pulse got %0b expected 0", buf_in_commit_ack); end
            end
            n_tests++; if (buf_out_q !== DATA_W'(8'hA0 + i)) begin n_fail++; $display("FAIL read_%0d got %0h expected %0h", i, buf_out_q, 8'hA0 + i); end
        end
        buf_out_arm = 1'b1;
        tick();
        buf_out_arm = 1'b0;
        n_tests++; if (buf_out_arm_ack !== 1'b1) begin n_fail++; $display("FAIL arm_ack got %0b expected 1", buf_out_arm_ack); end
        n_tests++; if (buf_out_hasdata !== 1'b0) begin n_fail++; $display("FAIL arm_hasdata got %0b expected 0", buf_out_hasdata); end
        tick();
        n_tests++; if (buf_out_arm_ack !== 1'b0) begin n_fail++; $display("FAIL arm_ack_pulse got %0b expected 0", buf_out_arm_ack); end
    endtask

    task automatic test_full();
        do_reset();
        write_byte(0, 8'h55);
        for (int i = 0; i < 5; i++) begin
            buf_in_commit = 1'b1;
            buf_in_commit_len = LEN_W'(i + 1);
            tick();
            buf_in_commit = 1'b0;
            n_tests++; if (buf_in_commit_ack !== (i < 4)) begin n_fail++; $display("FAIL full_ack_%0d got %0b expected %0b", i, buf_in_commit_ack, i < 4); end
`ifdef USB2_EP_OVERFLOW_STAT_EN
            n_tests++; if (buf_in_overflow !== (i == 4)) begin n_fail++; $display("FAIL full_ovf_%0d got %0b expected %0b", i, buf_in_overflow, i == 4); end
`endif
        end
        n_tests++; if (buf_count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d expected 4", buf_count); end
        n_tests++; if (buf_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b expected 0", buf_in_ready); end
        write_byte(0, 8'hFF);
        buf_out_addr = '0;
        tick();
        n_tests++; if (buf_out_q !== 8'h55) begin n_fail++; $display("FAIL full_nocorrupt got %0h expected 55", buf_out_q); end
        n_tests++; if (buf_out_len !== 10'd1) begin n_fail++; $display("FAIL full_len0 got %0d expected 1", buf_out_len); end
    endtask

    task automatic test_simultaneous();
        buf_in_commit = 1'b1;
        buf_in_commit_len = 10'd7;
        buf_out_arm = 1'b1;
        tick();
        buf_in_commit = 1'b0;
        buf_out_arm = 1'b0;
        n_tests++; if (buf_out_arm_ack !== 1'b1) begin n_fail++; $display("FAIL sim_full_arm got %0b expected 1", buf_out_arm_ack); end
        n_tests++; if (buf_in_commit_ack !== 1'b0) begin n_fail++; $display("FAIL sim_full_commit got %0b expected 0", buf_in_commit_ack); end
        n_tests++; if (buf_count !== 3'd3) begin n_fail++; $display("FAIL sim_full_count got %0d expected 3", buf_count); end
        n_tests++; if (buf_out_len !== 10'd2) begin n_fail++; $display("FAIL sim_full_len got %0d expected 2", buf_out_len); end
        buf_out_arm = 1'b1;
        tick(); tick(); tick();
        buf_out_arm = 1'b0;
        n_tests++; if (buf_count !== 3'd0) begin n_fail++; $display("FAIL drain_count got %0d expected 0", buf_count); end
        buf_in_commit = 1'b1;
        buf_in_commit_len = 10'd9;
        buf_out_arm = 1'b1;
        tick();
        buf_in_commit = 1'b0;
        buf_out_arm = 1'b0;
        n_tests++; if (buf_in_commit_ack !== 1'b1) begin n_fail++; $display("FAIL sim_empty_commit got %0b expected 1", buf_in_commit_ack); end
        n_tests++; if (buf_out_arm_ack !== 1'b0) begin n_fail++; $display("FAIL sim_empty_arm got %0b expected 0", buf_out_arm_ack); end
        n_tests++; if (buf_count !== 3'd1) begin n_fail++; $display("FAIL sim_empty_count got %0d expected 1", buf_count); end
        n_tests++; if (buf_out_len !== 10'd9) begin n_fail++; $display("FAIL sim_empty_len got %0d expected 9", buf_out_len); end
        buf_in_commit = 1'b1;
        buf_in_commit_len = 10'd11;
        buf_out_arm = 1'b1;
        tick();
        buf_in_commit = 1'b0;
        buf_out_arm = 1'b0;
        n_tests++; if ({buf_in_commit_ack, buf_out_arm_ack} !== 2'b11) begin n_fail++; $display("FAIL sim_mid_acks got %b expected 11", {buf_in_commit_ack, buf_out_arm_ack}); end
        n_tests++; if (buf_count !== 3'd1 || buf_out_len !== 10'd11) begin n_fail++; $display("FAIL sim_mid_state got count %0d len %0d expected count 1 len 11", buf_count, buf_out_len); end
        buf_out_arm = 1'b1;
        tick();
        buf_out_arm = 1'b0;
    endtask

    task automatic test_len_edge();
        buf_in_commit = 1'b1;
        buf_in_commit_len = 10'd0;
        tick();
        buf_in_commit = 1'b0;
        n_tests++; if (buf_out_hasdata !== 1'b1 || buf_out_len !== 10'd0) begin n_fail++; $display("FAIL zlp got hasdata %0b len %0d expected hasdata 1 len 0", buf_out_hasdata, buf_out_len); end
        buf_out_arm = 1'b1;
        tick();
        buf_out_arm = 1'b0;
        n_tests++; if (buf_out_hasdata !== 1'b0) begin n_fail++; $display("FAIL zlp_arm got %0b expected 0", buf_out_hasdata); end
        buf_in_commit = 1'b1;
        buf_in_commit_len = 10'd600;
        tick();
        buf_in_commit = 1'b0;
        n_tests++; if (buf_out_len !== 10'd512) begin n_fail++; $display("FAIL len_clamp got %0d expected 512", buf_out_len); end
        buf_out_arm = 1'b1;
        tick();
        buf_out_arm = 1'b0;
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) write_byte(j * 3, k * 16 + j);
            buf_in_commit = 1'b1;
            buf_in_commit_len = LEN_W'(k + 20);
            tick();
            buf_in_commit = 1'b0;
            n_tests++; if (buf_out_len !== LEN_W'(k + 20)) begin n_fail++; $display("FAIL wrap_len_%0d got %0d expected %0d", k, buf_out_len, k + 20); end
            for (int j = 0; j < 4; j++) begin
                buf_out_addr = BUF_ADDR_W'(j * 3);
                tick();
                n_tests++; if (buf_out_q !== DATA_W'(k * 16 + j)) begin n_fail++; $display("FAIL wrap_%0d_%0d got %0h expected %0h", k, j, buf_out_q, k * 16 + j); end
            end
            buf_out_arm = 1'b1;
            tick();
            buf_out_arm = 1'b0;
        end
        n_tests++; if (buf_count !== 3'd0) begin n_fail++; $display("FAIL wrap_count got %0d expected 0", buf_count); end
    endtask

    task automatic test_toggle();
        logic [1:0] exp_seq [3];
        exp_seq[0] = DATA_TOGGLE_1;
        exp_seq[1] = DATA_TOGGLE_0;
        exp_seq[2] = DATA_TOGGLE_1;
        mode = EP_MODE_BULK;
        data_toggle_clear = 1'b1;
        tick();
        data_toggle_clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_toggle_act = 1'b1;
            tick();
            data_toggle_act = 1'b0;
            n_tests++; if (data_toggle !== exp_seq[i]) begin n_fail++; $display("FAIL toggle_bulk_%0d got %0d expected %0d", i, data_toggle, exp_seq[i]); end
        end
        mode = EP_MODE_ISOCH;
        tick();
        n_tests++; if (data_toggle !== DATA_TOGGLE_1) begin n_fail++; $display("FAIL toggle_mode_chg got %0d expected 1", data_toggle); end
        mode = EP_MODE_BULK;
        data_toggle_act = 1'b1;
        data_toggle_clear = 1'b1;
        tick();
        data_toggle_act = 1'b0;
        data_toggle_clear = 1'b0;
        n_tests++; if (data_toggle !== DATA_TOGGLE_0) begin n_fail++; $display("FAIL toggle_clear got %0d expected 0", data_toggle); end
        mode = EP_MODE_ISOCH;
        for (int i = 0; i < 2; i++) begin
            data_toggle_act = 1'b1;
            tick();
            data_toggle_act = 1'b0;
            n_tests++; if (data_toggle !== DATA_TOGGLE_0) begin n_fail++; $display("FAIL toggle_isoch_%0d got %0d expected 0", i, data_toggle); end
        end
        mode = EP_MODE_CONTROL;
        data_toggle_act = 1'b1;
        tick();
        data_toggle_act = 1'b0;
        n_tests++; if (data_toggle !== DATA_TOGGLE_1) begin n_fail++; $display("FAIL toggle_ctrl got %0d expected 1", data_toggle); end
    endtask

    task automatic test_reset_mid();
        buf_in_commit = 1'b1;
        buf_in_commit_len = 10'd5;
        tick();
        tick();
        buf_in_commit = 1'b0;
        n_tests++; if (buf_count !== 3'd2) begin n_fail++; $display("FAIL mid_precount got %0d expected 2", buf_count); end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if (buf_in_ready !== 1'b1 || buf_out_hasdata !== 1'b0) begin n_fail++; $display("FAIL mid_async got ready %0b hasdata %0b expected ready 1 hasdata 0", buf_in_ready, buf_out_hasdata); end
        n_tests++; if (buf_count !== 3'd0 || data_toggle !== 2'b00) begin n_fail++; $display("FAIL mid_state got count %0d toggle %0d expected 0 0", buf_count, data_toggle); end
        @(posedge phy_clk);
        #3;
        reset_n = 1'b1;
        tick();
        n_tests++; if (buf_count !== 3'd0 || buf_out_len !== 10'd0) begin n_fail++; $display("FAIL mid_after got count %0d len %0d expected 0 0", buf_count, buf_out_len); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_full();
        test_simultaneous();
        test_len_edge();
        test_wrap();
        test_toggle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
